// File: rtl/bsg_fsb_murn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fsb_murn_pkg
// Description : Shared switch-packet opcodes, broadcast-ID helper and FSB
//               packet field extractors for the multi-node murn gateway.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_fsb_murn_pkg;

    // Widest packet the field helpers accept; callers zero-extend into this.
    localparam int c_max_w = 256;

    localparam logic [3:0] c_op_enable         = 4'h1;
    localparam logic [3:0] c_op_disable        = 4'h2;
    localparam logic [3:0] c_op_assert_reset   = 4'h3;
    localparam logic [3:0] c_op_deassert_reset = 4'h4;
    localparam logic [3:0] c_op_pulse_reset    = 4'h5;
    localparam logic [3:0] c_op_clear_drops    = 4'h6;

    // All-ones ID of the given width addresses every node at once.
    function automatic logic [31:0] bcast_id(input int id_width);
        if (id_width >= 32)
            return '1;
        return (32'd1 << id_width) - 32'd1;
    endfunction

    // Destination ID occupies the top id_width bits of the packet.
    function automatic logic [31:0] pkt_dest(input logic [c_max_w-1:0] pkt,
                                             input int width, input int id_width);
        logic [c_max_w-1:0] s;
        s = pkt >> (width - id_width);
        return 32'(s) & bcast_id(id_width);
    endfunction

    // Command flag sits just below the destination field.
    function automatic logic pkt_cmd(input logic [c_max_w-1:0] pkt,
                                     input int width, input int id_width);
        logic [c_max_w-1:0] s;
        s = pkt >> (width - id_width - 1);
        return s[0];
    endfunction

    function automatic logic [3:0] pkt_opcode(input logic [c_max_w-1:0] pkt);
        return pkt[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_fsb_murn_gateway_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fsb_murn_gateway_multi_if
// Description : Inbound FSB handshake plus the per-node outbound fan-out.
//               Signal names are from the gateway's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface bsg_fsb_murn_gateway_multi_if #(
    parameter int width_p     = 80,
    parameter int num_nodes_p = 4
);
    logic                   v_i;
    logic [width_p-1:0]     data_i;
    logic                   ready_o;
    logic [num_nodes_p-1:0] v_o;
    logic [width_p-1:0]     data_o;
    logic [num_nodes_p-1:0] ready_i;

    // Gateway side
    modport slave (
        input  v_i, data_i, ready_i,
        output ready_o, v_o, data_o
    );

    // Ring source and node side
    modport master (
        output v_i, data_i, ready_i,
        input  ready_o, v_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_fsb_murn_node_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fsb_murn_node_ctrl
// Description : Enable, reset and timed reset-pulse state for one node.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_fsb_murn_node_ctrl
    import bsg_fsb_murn_pkg::*;
#(
    parameter int reset_pulse_cycles_p = 16
) (
    input  wire logic       clk_i,
    input  wire logic       reset_i,
    input  wire logic       cmd_v_i,
    input  wire logic [3:0] opcode_i,
    output logic            en_r_o,
    output logic            reset_r_o
);
    localparam int                 c_cnt_w     = $clog2(reset_pulse_cycles_p + 1);
    localparam logic [c_cnt_w-1:0] c_pulse_len = c_cnt_w'(reset_pulse_cycles_p);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    logic               en_q, en_d;
    logic               reset_q, reset_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    // Pulse countdown first, then a command this cycle overrides it.
    always_comb begin
        en_d    = en_q;
        reset_d = reset_q;
        cnt_d   = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - c_one;
            if (cnt_q == c_one)
                reset_d = 1'b0;
        end
        if (cmd_v_i) begin
            case (opcode_i)
                c_op_enable:         en_d = 1'b1;
                c_op_disable:        en_d = 1'b0;
                c_op_assert_reset:   begin reset_d = 1'b1; cnt_d = '0; end
                c_op_deassert_reset: begin reset_d = 1'b0; cnt_d = '0; end
                c_op_pulse_reset:    begin reset_d = 1'b1; cnt_d = c_pulse_len; end
                default:             ;
            endcase
        end
    end

    // Node state register; nodes come out of reset disabled and held in reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q    <= 1'b0;
            reset_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            en_q    <= en_d;
            reset_q <= reset_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en_r_o    = en_q;
    assign reset_r_o = reset_q;

endmodule
`default_nettype wire

// File: rtl/bsg_fsb_murn_gateway_multi.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fsb_murn_gateway_multi
// Description : FSB gateway serving num_nodes_p consecutive node IDs. Decodes
//               switch packets into per-node control, steers data packets to
//               the addressed enabled node and counts drops to disabled ones.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_fsb_murn_gateway_multi
    import bsg_fsb_murn_pkg::*;
#(
    parameter int width_p              = 80,
    parameter int id_width_p           = 4,
    parameter int id_base_p            = 0,
    parameter int num_nodes_p          = 4,
    parameter int reset_pulse_cycles_p = 16,
    parameter int drop_width_p         = 16
) (
    input  wire logic                    clk_i,
    input  wire logic                    reset_i,
    bsg_fsb_murn_gateway_multi_if.slave  fsb_if,
    output logic [num_nodes_p-1:0]       node_en_r_o,
    output logic [num_nodes_p-1:0]       node_reset_r_o,
    output logic [drop_width_p-1:0]      drop_count_r_o
);
    logic [c_max_w-1:0]     w_pkt;
    logic [31:0]            w_dest;
    logic                   w_cmd;
    logic [3:0]             w_op;
    logic                   w_bcast;
    logic [num_nodes_p-1:0] w_sel;
    logic                   w_live, w_data_v, w_sw_v;
    logic                   w_sel_en, w_sel_rdy, w_deliver;
    logic                   w_drop, w_clr;

    logic [drop_width_p-1:0] drop_count_q, drop_count_d;

    assign w_pkt   = c_max_w'(fsb_if.data_i);
    assign w_dest  = pkt_dest(w_pkt, width_p, id_width_p);
    assign w_cmd   = pkt_cmd(w_pkt, width_p, id_width_p);
    assign w_op    = pkt_opcode(w_pkt);
    assign w_bcast = (w_dest == bcast_id(id_width_p));

    // One-hot decode of the served node; doubles as the per-node select.
    for (genvar k = 0; k < num_nodes_p; k++) begin : g_node
        assign w_sel[k] = (w_dest == 32'(id_base_p + k));

        bsg_fsb_murn_node_ctrl #(
            .reset_pulse_cycles_p (reset_pulse_cycles_p)
        ) u_node_ctrl (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .cmd_v_i   (w_sw_v & (w_sel[k] | w_bcast)),
            .opcode_i  (w_op),
            .en_r_o    (node_en_r_o[k]),
            .reset_r_o (node_reset_r_o[k])
        );
    end

    // Nothing is offered or consumed while the gateway itself is in reset.
    assign w_live    = fsb_if.v_i & ~reset_i;
    assign w_data_v  = w_live & ~w_cmd;
    assign w_sw_v    = w_live & w_cmd;
    assign w_sel_en  = |(w_sel & node_en_r_o);
    assign w_sel_rdy = |(w_sel & fsb_if.ready_i);
    assign w_deliver = w_data_v & w_sel_en;

    // Only a delivered packet waits on the node; everything else is swallowed.
    assign fsb_if.v_o     = w_deliver ? (w_sel & node_en_r_o) : '0;
    assign fsb_if.ready_o = w_deliver ? w_sel_rdy : w_live;
    assign fsb_if.data_o  = fsb_if.data_i;

    assign w_drop = w_data_v & (|w_sel) & ~w_sel_en;
    assign w_clr  = w_sw_v & ((|w_sel) | w_bcast) & (w_op == c_op_clear_drops);

    // Saturating drop counter; clear and increment are mutually exclusive.
    always_comb begin
        drop_count_d = drop_count_q;
        if (w_clr)
            drop_count_d = '0;
        else if (w_drop && !(&drop_count_q))
            drop_count_d = drop_count_q + drop_width_p'(1);
    end

    // Drop counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            drop_count_q <= '0;
        else
            drop_count_q <= drop_count_d;
    end

    assign drop_count_r_o = drop_count_q;

endmodule
`default_nettype wire

// File: doc/bsg_fsb_murn_gateway_multi.md
Name: bsg_fsb_murn_gateway_multi

Overview:
Parametrised successor to the single-node FSB murn gateway. One gateway fronts num_nodes_p consecutive node IDs on the FSB ring. It decodes switch (command) packets into per-node enable/reset state, adds a self-timing reset pulse and broadcast commands, and steers data packets to the addressed enabled node. Packets addressed to disabled nodes are consumed, dropped and counted in a saturating counter.

Parameters:
width_p, 80, FSB packet width in bits.
id_width_p, 4, destination ID field width.
id_base_p, 0, node ID served by output index 0; this gateway serves IDs id_base_p .. id_base_p+num_nodes_p-1.
num_nodes_p, 4, number of nodes served (1..2^id_width_p-1).
reset_pulse_cycles_p, 16, length in cycles of a timed reset pulse (>=1).
drop_width_p, 16, width of the drop counter.

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous, active-high reset.
v_i  in  1  inbound packet valid.
data_i  in  width_p  inbound packet.
ready_o  out  1  packet consumed this cycle (may depend combinationally on v_i and ready_i).
v_o  out  num_nodes_p  one-hot valid toward node k.
data_o  out  width_p  equals data_i (shared by all nodes).
ready_i  in  num_nodes_p  node k accepts the packet.
node_en_r_o  out  num_nodes_p  registered per-node enable.
node_reset_r_o  out  num_nodes_p  registered per-node reset.
drop_count_r_o  out  drop_width_p  saturating count of dropped data packets.

Behaviour:
- Interface: one clock, clk_i. reset_i is synchronous and active-high.
- Packet fields:
  - dest = data_i[width_p-1 -: id_width_p].
  - cmd = data_i[width_p-id_width_p-1].
  - opcode = data_i[3:0] (meaningful only when cmd=1).
- Node index k = dest - id_base_p when dest is in range.
- Broadcast ID = all ones. It applies to switch packets only and must not fall inside the served range.
- Reset state: node_en_r_o=0, node_reset_r_o=all 1, pulse counters=0, drop_count_r_o=0. While reset_i=1: ready_o=0 and v_o=0.
- Data packet (cmd=0), dest in range, en[k]=1: v_o[k]=v_i; ready_o=v_i&ready_i[k]. Zero latency, no storage.
- Data packet, dest in range, en[k]=0: ready_o=v_i; v_o=0; drop counter increments by 1 and saturates at all ones.
- Data packet with dest out of range or broadcast: ready_o=v_i, v_o=0, not counted. Other gateways on the ring own it.
- Switch packet (cmd=1) to in-range k, or broadcast (all k): ready_o=v_i, v_o=0. Effect is registered at the next edge.
  - 0x1: en=1.
  - 0x2: en=0.
  - 0x3: reset=1 (persistent); cancels any pulse.
  - 0x4: reset=0; cancels any pulse.
  - 0x5: reset=1 and pulse counter=reset_pulse_cycles_p. The counter decrements each cycle. When it reaches 0, reset drops to 0 at that edge, so node_reset_r_o is high for exactly reset_pulse_cycles_p cycles after the command edge. A 0x5 during a running pulse restarts the count.
  - 0x6: clear drop counter to 0. Any node index or broadcast is accepted.
  - Other opcodes: consumed, no effect.
  - Switch packets to out-of-range IDs: consumed, ignored.
- Enable and reset are independent. A data packet to an enabled node in reset is still delivered; the node is responsible for gating it.
- Simultaneous events:
  - A drop increment and a 0x6 clear cannot occur in the same cycle (single input).
  - A pulse expiring in the same cycle as a 0x3/0x4 command to that node: the command wins.
- reset_i asserted mid-pulse: state returns to reset values next edge; the pulse is abandoned.
- Pulse counter width: $clog2(reset_pulse_cycles_p+1).

Decomposition:
- Shared package bsg_fsb_murn_pkg holds:
  - opcode constants (enable, disable, assert_reset, deassert_reset, pulse_reset, clear_drops);
  - broadcast-ID function of id_width_p;
  - packet field-extract helpers.
- One sub-module, bsg_fsb_murn_node_ctrl, instantiated num_nodes_p times. It holds en, reset and the pulse counter for one node. Inputs: cmd_v, opcode. Outputs: en_r, reset_r.
- The top level holds the address decode, the handshake mux and the drop counter.

Test Plan:
- Out of reset: node_en_r_o=0000, node_reset_r_o=1111, drop_count_r_o=0; v_i=0 -> ready_o=0.
- Switch 0x1 then 0x4 to dest=id_base_p+2 -> node_en_r_o=0100, node_reset_r_o=1011. A following data packet to node 2 with ready_i[2]=0 then 1 -> v_o=0100 both cycles; ready_o=0 then 1.
- Data to disabled node 1, 3 packets back-to-back -> ready_o=1 each cycle, v_o=0, drop_count_r_o=3. Then switch 0x6 -> 0. With drop_width_p=2, 5 drops -> saturates at 3.
- Broadcast 0x5 with reset_pulse_cycles_p=16 -> all node_reset_r_o high 16 cycles, then 0000. 0x5 to node 0 at cycle 8 of the pulse -> node 0 stays high 16 more cycles.
- Data to dest=id_base_p+num_nodes_p (out of range) -> ready_o=1, v_o=0, counter unchanged.
- reset_i pulsed mid-pulse with nodes enabled -> next cycle all outputs at reset values; pulse does not resume.
